load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Core-side initiator for the word-addressed, synchronous-read data memory. It accepts one load or store request at a time from the execute stage and issues the word accesses to the memory. Sub-word loads (LB/LH/LBU/LHU) are extracted and extended here. Sub-word stores (SB/SH) are handled as read-modify-write, because the memory only accepts full-word writes.

Parameters:
CHECK_ALIGN, 1, 1 = misaligned LH/LHU/SH/LW/SW are rejected with o_err; 0 = low address bits are ignored and the access is treated as aligned to its natural size.

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous, active-high reset
i_valid  input  1  request strobe, sampled only when o_ready=1
i_store  input  1  1 = store, 0 = load
i_funct3  input  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_addr  input  32  byte address
i_wdata  input  32  store data, low bits used for B/H
o_ready  output  1  unit idle, able to accept a request
o_done  output  1  one-cycle completion pulse
o_err  output  1  valid with o_done; request was misaligned or illegal
o_rdata  output  32  extended load result; holds until the next load completes
o_mem_we  output  1  memory write enable
o_mem_addr  output  32  memory byte address, always word-aligned {addr[31:2],2'b00}
o_mem_wdata  output  32  memory write data
i_mem_rdata  input  32  memory read data, valid the cycle after the address is presented

Behaviour:
- Memory model: the memory samples the address at the posedge and registers the read data. Data is valid on i_mem_rdata during the cycle after the address was driven. A write and a read at the same edge return the old word.
- FSM states: IDLE, ACCESS, CAPTURE, WRITE, RESP.
- On reset, from any state, immediately: state=IDLE, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_done=0, o_err=0, o_rdata=0, o_ready=1.
- IDLE: o_ready=1. On i_valid, latch addr, funct3, store flag and wdata, then classify:
  - illegal (funct3 011/110/111, or store with 100/101), or misaligned with CHECK_ALIGN=1 (H: addr[0]!=0; W: addr[1:0]!=0) -> RESP with err=1, no memory access;
  - SW -> WRITE;
  - any load, SB or SH -> ACCESS.
- ACCESS: drive o_mem_addr, o_mem_we=0 -> CAPTURE.
- CAPTURE, load:
  - select the lane by addr[1:0] (B) or addr[1] (H); byte lane 0 = bits [7:0];
  - sign-extend for 000/001, zero-extend for 100/101, pass the word through for 010;
  - register the result into o_rdata -> RESP.
- CAPTURE, SB/SH: merge the lane(s) of wdata into i_mem_rdata and register the result into the write buffer -> WRITE.
- WRITE: o_mem_we=1, o_mem_addr held, o_mem_wdata = buffer (SW: i_wdata unchanged) -> RESP.
- RESP: o_done=1 for exactly one cycle, o_err per classification -> IDLE. o_ready=0 in RESP.
- o_mem_we is high only in WRITE, for exactly one cycle per store. It is never high for loads or errored requests.
- Latency from the accepting edge to o_done high:
  - error: 1 cycle;
  - SW: 2;
  - loads: 3;
  - SB/SH: 4.
- Throughput: the next request is accepted in the cycle after RESP. i_valid while o_ready=0 is ignored and not queued.
- On an errored load, o_rdata is left unchanged. On a store, o_rdata is left unchanged.
- Reset mid-operation (for example during WRITE) aborts the transaction; no partial write occurs after reset deassertion.
- With CHECK_ALIGN=0, misaligned H uses lane addr[1] and W ignores addr[1:0]. o_err is then raised only for illegal funct3.

Test Plan:
- Memory word 0x40 = 0x8899AABB; LB @0x41 -> o_rdata=0xFFFFFFAA, o_done 3 cycles after acceptance; LBU @0x43 -> 0x00000088; LH @0x42 -> 0xFFFF8899; LHU @0x40 -> 0x0000AABB.
- SW 0x12345678 @0x80 -> one o_mem_we pulse, o_mem_addr=0x80, o_mem_wdata=0x12345678, o_done 2 cycles after acceptance; then LW @0x80 -> 0x12345678.
- Word 0x80 = 0x12345678; SB wdata=0xFFFFFFCD @0x82 -> stored word 0x12CD5678; SH wdata=0x0000BEEF @0x80 -> 0x12CDBEEF; one we pulse each, o_done 4 cycles after acceptance.
- LW @0x42, SH @0x81, and funct3=011 load -> o_done + o_err 1 cycle after acceptance, no o_mem_we, o_rdata unchanged.
- i_valid held high continuously during an SB -> second request accepted only in the cycle after RESP; exactly one transaction per o_ready window.
- Assert i_rst during WRITE of SB @0x84 -> o_mem_we drops to 0 immediately, no write after release, state IDLE, o_ready=1, all outputs 0.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for a word-addressed,
// synchronous-read data memory. Sub-word loads are extracted and extended here;
// sub-word stores are done as read-modify-write since the memory takes whole words.
module load_store_unit #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] wbuf_q, wbuf_d;

    logic        illegal, misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext, st_merge;

    // Request classification and lane extraction/merge for the latched request.
    always_comb begin
        illegal    = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111) ||
                     (i_store && i_funct3[2]);
        misaligned = CHECK_ALIGN && (((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                                     ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00)));

        ld_byte = i_mem_rdata[8*addr_q[1:0] +: 8];
        ld_half = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = i_mem_rdata;
        endcase

        st_merge = i_mem_rdata;
        if (funct3_q[1:0] == 2'b00)
            st_merge[8*addr_q[1:0] +: 8] = wdata_q[7:0];
        else
            st_merge[16*addr_q[1] +: 16] = wdata_q[15:0];
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        store_d  = store_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        wbuf_d   = wbuf_q;
        case (state_q)
            IDLE: if (i_valid) begin
                addr_d   = i_addr;
                funct3_d = i_funct3;
                store_d  = i_store;
                wdata_d  = i_wdata;
                wbuf_d   = i_wdata;  // SW writes the store data as-is
                err_d    = illegal || misaligned;
                if (illegal || misaligned)           state_d = RESP;
                else if (i_store && i_funct3 == 3'b010) state_d = WRITE;
                else                                 state_d = ACCESS;
            end
            ACCESS:  state_d = CAPTURE;
            CAPTURE: begin
                if (store_q) begin
                    wbuf_d  = st_merge;
                    state_d = WRITE;
                end else begin
                    rdata_d = ld_ext;
                    state_d = RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; async reset aborts any transaction.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            wbuf_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            store_q  <= store_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            wbuf_q   <= wbuf_d;
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_done      = (state_q == RESP);
    assign o_err       = (state_q == RESP) && err_q;
    assign o_rdata     = rdata_q;
    assign o_mem_we    = (state_q == WRITE);
    assign o_mem_addr  = {addr_q[31:2], 2'b00};
    assign o_mem_wdata = wbuf_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural synchronous-read memory.
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid, i_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic        o_ready, o_done, o_err, o_mem_we;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata, i_mem_rdata;

    int n_chk = 0;
    int n_fail = 0;

    // bench-side preload port into the memory model
    logic        pl_we = 1'b0;
    logic [31:0] pl_addr = '0, pl_data = '0;
    logic [31:0] mem [0:255];

    always #5 i_clk = ~i_clk;

    // Synchronous-read memory: read returns the old word on a same-edge write.
    always @(posedge i_clk) begin
        i_mem_rdata <= mem[o_mem_addr[9:2]];
        if (o_mem_we)   mem[o_mem_addr[9:2]] <= o_mem_wdata;
        else if (pl_we) mem[pl_addr[9:2]]    <= pl_data;
    end

    load_store_unit #(.CHECK_ALIGN(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_store(i_store),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_ready(o_ready), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata)
    );

    // results of the last request
    int          r_lat, r_we;
    logic        r_err, r_rdy_in_resp;
    logic [31:0] r_waddr, r_wdata;

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge i_clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge i_clk);
        pl_we = 1'b0;
    endtask

    task automatic run_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        @(negedge i_clk);
        i_valid = 1'b1; i_store = st; i_funct3 = f3; i_addr = a; i_wdata = wd;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        r_lat = -1; r_we = 0; r_err = 1'b0; r_rdy_in_resp = 1'b1;
        r_waddr = '0; r_wdata = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge i_clk);
            if (o_mem_we) begin
                r_we++; r_waddr = o_mem_addr; r_wdata = o_mem_wdata;
            end
            if (o_done) begin
                r_lat = n; r_err = o_err; r_rdy_in_resp = o_ready;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        n_chk++;
        if ({o_ready, o_done, o_err, o_mem_we} !== 4'b1000 || o_rdata !== 32'd0 ||
            o_mem_addr !== 32'd0 || o_mem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy/done/err/we=%b rdata=%h addr=%h wdata=%h, required 1000/0/0/0",
                     {o_ready, o_done, o_err, o_mem_we}, o_rdata, o_mem_addr, o_mem_wdata);
        end
        @(negedge i_clk); i_rst = 1'b0;
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] exp, input string nm);
        run_req(1'b0, f3, a, 32'd0);
        n_chk++;
        if (o_rdata !== exp || r_lat != 3 || r_we != 0 || r_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: rdata=%h lat=%0d we=%0d err=%b, required %h lat=3 we=0 err=0",
                     nm, o_rdata, r_lat, r_we, r_err, exp);
        end
    endtask

    task automatic test_sw;
        run_req(1'b1, 3'b010, 32'h80, 32'h12345678);
        n_chk++;
        if (r_lat != 2 || r_we != 1 || r_waddr !== 32'h80 || r_wdata !== 32'h12345678 || r_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sw: lat=%0d we=%0d addr=%h data=%h err=%b, required lat=2 we=1 addr=80 data=12345678 err=0",
                     r_lat, r_we, r_waddr, r_wdata, r_err);
        end
        n_chk++;
        if (r_rdy_in_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_in_resp: o_ready=%b, required 0", r_rdy_in_resp);
        end
        test_load(3'b010, 32'h80, 32'h12345678, "lw_after_sw");
    endtask

    task automatic test_err(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] keep, input string nm);
        run_req(st, f3, a, 32'hDEADBEEF);
        n_chk++;
        if (r_lat != 1 || r_err !== 1'b1 || r_we != 0 || o_rdata !== keep) begin
            n_fail++;
            $display("FAIL %s: lat=%0d err=%b we=%0d rdata=%h, required lat=1 err=1 we=0 rdata=%h",
                     nm, r_lat, r_err, r_we, o_rdata, keep);
        end
    endtask

    task automatic test_subword_store(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [31:0] exp,
                                      input logic [31:0] keep, input string nm);
        run_req(1'b1, f3, a, wd);
        @(negedge i_clk);
        n_chk++;
        if (r_lat != 4 || r_we != 1 || r_waddr !== 32'h80 || r_wdata !== exp ||
            mem[32'h80 >> 2] !== exp || o_rdata !== keep) begin
            n_fail++;
            $display("FAIL %s: lat=%0d we=%0d addr=%h data=%h mem=%h rdata=%h, required lat=4 we=1 addr=80 data=%h rdata=%h",
                     nm, r_lat, r_we, r_waddr, r_wdata, mem[32'h80 >> 2], o_rdata, exp, keep);
        end
    endtask

    task automatic test_back_to_back;
        int rdy_cnt, we_cnt, done_cnt, second_rdy;
        rdy_cnt = 0; we_cnt = 0; done_cnt = 0; second_rdy = -1;
        @(negedge i_clk);
        i_valid = 1'b1; i_store = 1'b1; i_funct3 = 3'b000; i_addr = 32'h88; i_wdata = 32'h11;
        for (int n = 0; n < 10; n++) begin
            if (n > 0) @(negedge i_clk);
            if (o_ready) begin
                rdy_cnt++;
                if (n > 0 && second_rdy < 0) second_rdy = n;
            end
            if (o_mem_we) we_cnt++;
            if (o_done) done_cnt++;
        end
        i_valid = 1'b0;
        n_chk++;
        if (rdy_cnt != 2 || second_rdy != 5 || we_cnt != 2 || done_cnt != 2) begin
            n_fail++;
            $display("FAIL back_to_back: ready=%0d second_at=%0d we=%0d done=%0d, required 2/5/2/2",
                     rdy_cnt, second_rdy, we_cnt, done_cnt);
        end
        @(negedge i_clk);
        n_chk++;
        if (mem[32'h88 >> 2] !== 32'h00000011) begin
            n_fail++;
            $display("FAIL back_to_back_mem: mem=%h, required 00000011", mem[32'h88 >> 2]);
        end
    endtask

    task automatic test_reset_mid_write;
        int n, late_we;
        preload(32'h84, 32'hA5A5A5A5);
        @(negedge i_clk);
        i_valid = 1'b1; i_store = 1'b1; i_funct3 = 3'b000; i_addr = 32'h84; i_wdata = 32'h3C;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        n = 0;
        do begin
            @(negedge i_clk); n++;
        end while (!o_mem_we && n < 10);
        n_chk++;
        if (!o_mem_we) begin
            n_fail++;
            $display("FAIL reach_write: o_mem_we=%b after %0d cycles, required 1", o_mem_we, n);
        end
        i_rst = 1'b1;
        #1;
        n_chk++;
        if ({o_ready, o_done, o_err, o_mem_we} !== 4'b1000 || o_rdata !== 32'd0 ||
            o_mem_addr !== 32'd0 || o_mem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_write: rdy/done/err/we=%b rdata=%h addr=%h wdata=%h, required 1000/0/0/0",
                     {o_ready, o_done, o_err, o_mem_we}, o_rdata, o_mem_addr, o_mem_wdata);
        end
        @(negedge i_clk); @(negedge i_clk);
        i_rst = 1'b0;
        late_we = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            if (o_mem_we || !o_ready) late_we++;
        end
        n_chk++;
        if (late_we != 0 || mem[32'h84 >> 2] !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL no_write_after_reset: bad_cycles=%0d mem=%h, required 0 and a5a5a5a5",
                     late_we, mem[32'h84 >> 2]);
        end
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_store = 1'b0; i_funct3 = 3'b000;
        i_addr = '0; i_wdata = '0;
        for (int k = 0; k < 256; k++) mem[k] = 32'd0;
        test_reset;
        preload(32'h40, 32'h8899AABB);
        test_load(3'b000, 32'h41, 32'hFFFFFFAA, "lb_41");
        test_load(3'b100, 32'h43, 32'h00000088, "lbu_43");
        test_load(3'b001, 32'h42, 32'hFFFF8899, "lh_42");
        test_load(3'b101, 32'h40, 32'h0000AABB, "lhu_40");
        test_sw;
        test_err(1'b0, 3'b010, 32'h42, 32'h12345678, "lw_misaligned");
        test_err(1'b1, 3'b001, 32'h81, 32'h12345678, "sh_misaligned");
        test_err(1'b0, 3'b011, 32'h80, 32'h12345678, "illegal_011");
        test_err(1'b1, 3'b100, 32'h80, 32'h12345678, "illegal_store_bu");
        test_subword_store(3'b000, 32'h82, 32'hFFFFFFCD, 32'h12CD5678, 32'h12345678, "sb_82");
        test_subword_store(3'b001, 32'h80, 32'h0000BEEF, 32'h12CDBEEF, 32'h12345678, "sh_80");
        test_load(3'b010, 32'h80, 32'h12CDBEEF, "lw_after_rmw");
        test_back_to_back;
        test_reset_mid_write;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
